// File: rtl/fp_mc_pkg.sv
// Shared types for the multicycle FP issue slice: FSM encoding, widths, FIFO entry.
package fp_mc_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CHECK = 2'd2,
    WAIT  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] operand;
    logic [TAG_W-1:0]  tag;
  } entry_t;

endpackage

// File: rtl/fp_mc_fifo.sv
// DEPTH-entry synchronous request FIFO; flush wins over push and pop in the same cycle.
module fp_mc_fifo
  import fp_mc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  entry_t push_data,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fp_mc_issue.sv
// Issue sequencer for a multicycle FP unit: FIFO -> IDLE/ISSUE/CHECK/WAIT -> registered writeback.
// Optional watchdog timeout is built only when FP_MC_TIMEOUT_EN is defined.
module fp_mc_issue
  import fp_mc_pkg::*;
#(
  parameter int DEPTH          = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_operand,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic              flush,
  output logic              unit_valid,
  output logic [DATA_W-1:0] unit_operand,
  input  logic              unit_halt,
  input  logic [DATA_W-1:0] unit_result,
  output logic              wb_valid,
  output logic [TAG_W-1:0]  wb_tag,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_err,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              unit_valid_q, unit_valid_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              suppress_q, suppress_d;
  logic              wb_valid_q, wb_valid_d;
  logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_err_q, wb_err_d;
  logic              fifo_pop, fifo_full, fifo_empty, timeout;
  entry_t            fifo_head;

  fp_mc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_valid),
    .pop       (fifo_pop),
    .flush     (flush),
    .push_data ({req_operand, req_tag}),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

`ifdef FP_MC_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;

  // Counts completed cycles in CHECK/WAIT; zero everywhere else.
  always_comb begin
    wd_d    = ((state_q == CHECK) || (state_q == WAIT)) ? wd_q + WD_W'(1) : '0;
    timeout = (wd_q == WD_W'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge clk) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`else
  // No watchdog: the timeout term is a constant 0 and WAIT can last forever.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  // Handshakes: a request transfers on req_valid && req_ready; unit_valid is a
  // one-cycle start, and the unit result is taken on the first cycle after
  // the start where unit_halt is low.
  always_comb begin
    state_d      = state_q;
    unit_valid_d = 1'b0;
    operand_d    = operand_q;
    tag_d        = tag_q;
    suppress_d   = suppress_q | (flush && (state_q != IDLE));
    wb_valid_d   = 1'b0;
    wb_tag_d     = wb_tag_q;
    wb_data_d    = wb_data_q;
    wb_err_d     = 1'b0;
    fifo_pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !flush) begin
          state_d      = ISSUE;
          fifo_pop     = 1'b1;
          unit_valid_d = 1'b1;
          operand_d    = fifo_head.operand;
          tag_d        = fifo_head.tag;
          suppress_d   = 1'b0;
        end
      end
      ISSUE: state_d = CHECK;
      CHECK, WAIT: begin
        if (!unit_halt) begin
          state_d    = IDLE;
          wb_valid_d = !suppress_d;
          wb_tag_d   = tag_q;
          wb_data_d  = unit_result;
        end else if (timeout) begin
          state_d    = IDLE;
          wb_valid_d = !suppress_d;
          wb_tag_d   = tag_q;
          wb_data_d  = '0;
          wb_err_d   = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      unit_valid_q <= 1'b0;
      operand_q    <= '0;
      tag_q        <= '0;
      suppress_q   <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_tag_q     <= '0;
      wb_data_q    <= '0;
      wb_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      unit_valid_q <= unit_valid_d;
      operand_q    <= operand_d;
      tag_q        <= tag_d;
      suppress_q   <= suppress_d;
      wb_valid_q   <= wb_valid_d;
      wb_tag_q     <= wb_tag_d;
      wb_data_q    <= wb_data_d;
      wb_err_q     <= wb_err_d;
    end
  end

  assign req_ready    = !fifo_full;
  assign unit_valid   = unit_valid_q;
  assign unit_operand = operand_q;
  assign wb_valid     = wb_valid_q;
  assign wb_tag       = wb_tag_q;
  assign wb_data      = wb_data_q;
  assign wb_err       = wb_err_q;
  assign busy         = (state_q != IDLE) || !fifo_empty;

endmodule
